// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared UART definitions. The receiver state codes are kept here so the
//   transmitter and any debug/trace logic decode the same encoding.
//
//   Contents:
//     uart_state_e  - enumerated receiver states (for trace/debug decoding)
//     St*           - legacy-compatible localparam state codes used by the RTL
//     UART_BYTE_W   - width of the parallel data path
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned UART_STATE_W = 3;
    localparam int unsigned UART_BYTE_W  = 8;

    typedef enum logic [UART_STATE_W-1:0] {
        UartIdle     = 3'd0,
        UartStart    = 3'd1,
        UartData     = 3'd2,
        UartStop     = 3'd3,
        UartWaitHigh = 3'd4
    } uart_state_e;

    // Plain constants so legacy always_ff/case code can use the codes directly.
    localparam logic [UART_STATE_W-1:0] StIdle     = UartIdle;
    localparam logic [UART_STATE_W-1:0] StStart    = UartStart;
    localparam logic [UART_STATE_W-1:0] StData     = UartData;
    localparam logic [UART_STATE_W-1:0] StStop     = UartStop;
    localparam logic [UART_STATE_W-1:0] StWaitHigh = UartWaitHigh;

endpackage

// File: rtl/uart_bit_sync.sv
// ----------------------------------------------------------------------------
// uart_bit_sync
//   Two-flop synchronizer for a single asynchronous bit.
//
//   Parameters:
//     RESET_VAL - value both flops take on reset (1 for an idle-high line)
//   Ports:
//     clk - clock, rising edge
//     rst - synchronous active-high reset
//     d   - asynchronous input
//     q   - synchronized output (two cycles of latency)
// ----------------------------------------------------------------------------
module uart_bit_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], d};
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/uart_rx_deserializer.sv
// ----------------------------------------------------------------------------
// uart_rx_deserializer
//   UART receiver: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit.
//   The line is synchronized, the start bit is confirmed at its midpoint and
//   every following bit is sampled one bit period later. A completed byte is
//   held in rx_data with rx_valid until the consumer acknowledges it.
//
//   Parameters:
//     BAUD_DIV  - clock cycles per bit (even, >= 4)
//     DATA_BITS - data bits per frame (1..8)
//   Ports:
//     clk       - clock, rising edge
//     rst       - synchronous active-high reset
//     rx_in     - asynchronous serial line, idle high
//     rx_ack    - consumer acknowledges the held byte
//     rx_data   - last good byte, unused MSBs zero
//     rx_valid  - rx_data holds an unacknowledged byte
//     rx_busy   - receiver is not idle
//     frame_err - one-cycle pulse when a stop bit is sampled low
//     overrun   - sticky: a byte completed while the previous one was unread
// ----------------------------------------------------------------------------
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV  = 104,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    // Bits enter at the MSB of an 8-bit register, so a short frame ends up
    // left-aligned and has to be shifted down to the LSBs on load.
    localparam int unsigned OUT_SHIFT = UART_BYTE_W - DATA_BITS;

    // ------------------------------------------------------------------
    // Line synchronizer
    // ------------------------------------------------------------------
    logic rx_s;

    uart_bit_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [UART_STATE_W-1:0] state_q,     state_d;
    logic [CNT_W-1:0]        cnt_q,       cnt_d;
    logic [BIT_W-1:0]        bit_q,       bit_d;
    logic [7:0]              shift_q,     shift_d;
    logic [7:0]              rx_data_q,   rx_data_d;
    logic                    rx_valid_q,  rx_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    overrun_q,   overrun_d;

    // Sample-point strobes
    logic start_pt;
    logic data_pt;
    logic stop_pt;
    logic stop_good;

    always_comb begin
        start_pt  = (state_q == StStart) && (cnt_q == CNT_HALF);
        data_pt   = (state_q == StData)  && (cnt_q == CNT_FULL);
        stop_pt   = (state_q == StStop)  && (cnt_q == CNT_FULL);
        stop_good = stop_pt && rx_s;
    end

    // ------------------------------------------------------------------
    // Receive FSM, baud counter and shift register
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end

            StStart: begin
                if (start_pt) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A line back high at mid-start is a glitch: drop it.
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StData: begin
                if (data_pt) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == BIT_LAST) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StStop: begin
                if (stop_pt) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitHigh;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StWaitHigh: begin
                // Hold off until the line recovers so a break is not seen
                // as a stream of new start bits.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output holding register and handshake
    // ------------------------------------------------------------------
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;

        if (stop_good) begin
            // An ack landing with the new byte frees the slot in time.
            if (!rx_valid_q || rx_ack) begin
                rx_data_d  = shift_d >> OUT_SHIFT;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_ack) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_busy   = (state_q != StIdle);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_deserializer
//   Self-checking bench for uart_rx_deserializer at BAUD_DIV=16, DATA_BITS=8.
//   Expected bytes are queued as frames are sent and compared when rx_valid
//   rises; directed checks cover glitch, framing error, overrun, ack/complete
//   collision and mid-frame reset.
// ----------------------------------------------------------------------------
module tb_uart_rx_deserializer;

    localparam int unsigned B = 16;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       rx_in  = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    uart_rx_deserializer #(
        .BAUD_DIV  (B),
        .DATA_BITS (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Count of rising edges seen so far; edge number N sets cyc to N.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  sb_q[$];
    int unsigned rise_cyc  = 0;
    int unsigned frame_s   = 0;
    int unsigned fe_count  = 0;
    int unsigned glitch_s  = 0;
    logic        prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every rising rx_valid must match the oldest queued byte.
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_count++;
        if (rx_valid === 1'b1 && !prev_valid) begin
            rise_cyc = cyc;
            check("sb_nonempty", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) check("sb_data", rx_data, sb_q.pop_front());
        end
        prev_valid = (rx_valid === 1'b1);
    end

    // Drive one frame; ack_at/rst_at are cycle offsets from the start bit
    // (negative = unused). A reset aborts the frame two cycles after it starts.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input int ack_at, input int rst_at);
        for (int i = 0; i < 10 * B; i++) begin
            int k;
            @(negedge clk);
            if (i == 0) frame_s = cyc + 1;
            k = i / B;
            if (k == 0)      rx_in = 1'b0;
            else if (k == 9) rx_in = stop_bit;
            else             rx_in = data[k-1];
            rx_ack = (i == ack_at);
            if (rst_at >= 0 && i == rst_at) rst = 1'b1;
            if (rst_at >= 0 && i == rst_at + 2) begin
                rst   = 1'b0;
                rx_in = 1'b1;
                return;
            end
        end
        rx_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},     rx_data,   8'h00);
        check({tag, "_valid"},    rx_valid,  1'b0);
        check({tag, "_busy"},     rx_busy,   1'b0);
        check({tag, "_ferr"},     frame_err, 1'b0);
        check({tag, "_overrun"},  overrun,   1'b0);
    endtask

    initial begin
        idle(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(5);

        // Good frame 0xA5: value, latency and no framing error.
        sb_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, -1, -1);
        check("a5_latency", rise_cyc - frame_s, 154);
        check("a5_valid", rx_valid, 1'b1);
        check("a5_ferr_count", fe_count, 0);
        pulse_ack();
        check("a5_ack_clears", rx_valid, 1'b0);
        idle(10);

        // Four-cycle low glitch on an idle line.
        @(negedge clk);
        rx_in    = 1'b0;
        glitch_s = cyc + 1;
        idle(4);
        rx_in = 1'b1;
        idle(2);
        check("glitch_busy_mid", rx_busy, 1'b1);
        idle(6);
        check("glitch_cycle", cyc, glitch_s + 11);
        check("glitch_busy_end", rx_busy, 1'b0);
        idle(20);
        check("glitch_valid", rx_valid, 1'b0);
        check("glitch_ferr_count", fe_count, 0);

        // 0x3C with a low stop bit, then a 40-cycle break.
        send_frame(8'h3C, 1'b0, -1, -1);
        idle(40);
        check("ferr_wait_busy", rx_busy, 1'b1);
        check("ferr_count", fe_count, 1);
        check("ferr_data_kept", rx_data, 8'hA5);
        check("ferr_valid", rx_valid, 1'b0);
        rx_in = 1'b1;
        idle(4);
        check("ferr_recover_busy", rx_busy, 1'b0);
        idle(10);

        // Back-to-back 0x11, 0x22 with no ack: overrun.
        sb_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h22, 1'b1, -1, -1);
        idle(4);
        check("ovr_data", rx_data, 8'h11);
        check("ovr_valid", rx_valid, 1'b1);
        check("ovr_flag", overrun, 1'b1);
        pulse_ack();
        check("ovr_ack_clears", rx_valid, 1'b0);
        check("ovr_sticky", overrun, 1'b1);

        // Ack in the exact completion cycle of 0x22.
        do_reset();
        check("rst2_overrun", overrun, 1'b0);
        idle(5);
        sb_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h22, 1'b1, 154, -1);
        idle(2);
        check("coll_data", rx_data, 8'h22);
        check("coll_valid", rx_valid, 1'b1);
        check("coll_overrun", overrun, 1'b0);
        pulse_ack();
        idle(5);

        // Reset during data bit 4 of 0x5A, then receive 0x0F.
        send_frame(8'h5A, 1'b1, -1, 85);
        check_reset_outputs("midrst");
        idle(5);
        sb_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, -1, -1);
        idle(2);
        check("after_rst_data", rx_data, 8'h0F);
        check("after_rst_valid", rx_valid, 1'b1);
        check("after_rst_ferr_count", fe_count, 1);

        idle(5);
        check("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 104, clock cycles per bit (even, >= 4).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (1..8).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port rx_in, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port rx_ack, input, 1 bit: consumer acknowledges the held byte.
REQ-007 SHALL have port rx_data, output, 8 bits: last good byte, LSB-first assembled, unused MSBs 0.
REQ-008 SHALL have port rx_valid, output, 1 bit: rx_data holds an unacknowledged byte.
REQ-009 SHALL have port rx_busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-011 SHALL have port overrun, output, 1 bit: sticky; byte completed while rx_valid high and no rx_ack.

Function
REQ-012 SHALL pass rx_in through a 2-flop synchronizer (reset value 1); sync output = rx_s.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH with a baud counter cnt and a bit counter.
REQ-014 IDLE: rx_s==0 -> START, cnt=0; otherwise stay.
REQ-015 START: at cnt==BAUD_DIV/2-1, sample rx_s; 0 -> DATA, cnt=0, bit=0; 1 -> IDLE (glitch, no output).
REQ-016 DATA: at cnt==BAUD_DIV-1, shift rx_s into the MSB side of the shift register, cnt=0; after DATA_BITS samples -> STOP.
REQ-017 STOP: at cnt==BAUD_DIV-1, sample rx_s; 1 -> load rx_data, set rx_valid, -> IDLE; 0 -> pulse frame_err, rx_data unchanged, -> WAIT_HIGH.
REQ-018 WAIT_HIGH: stay until rx_s==1, then -> IDLE; prevents break conditions retriggering.
REQ-019 cnt SHALL be $clog2(BAUD_DIV) bits, never exceed BAUD_DIV-1, and wrap to 0 at each sample point.
REQ-020 Latency: if rx_in is first sampled low at edge S, rx_valid SHALL rise after edge S+2+BAUD_DIV/2+(DATA_BITS+1)*BAUD_DIV.
REQ-021 rx_ack with rx_valid high SHALL clear rx_valid on the next edge; rx_ack with rx_valid low is ignored.
REQ-022 Completion with rx_valid high and no rx_ack: rx_data keeps the old byte, rx_valid stays high, overrun set.
REQ-023 Completion in the same cycle as rx_ack: the new byte loads, rx_valid stays high, overrun unchanged.
REQ-024 overrun SHALL clear only on rst.
REQ-025 rx_ack SHALL NOT affect the receive state machine.

Reset
REQ-026 On rst: state IDLE, counters 0, synchronizer 1, rx_data 0x00, rx_valid 0, rx_busy 0, frame_err 0, overrun 0.
REQ-027 rst mid-frame SHALL abandon the frame with no rx_valid and no frame_err; reception restarts at the next low after release.

Structure
REQ-028 Package uart_pkg SHALL hold the state enum and the state-code constants shared with the transmitter.
REQ-029 The synchronizer SHALL be sub-module uart_bit_sync (2 flops, parameterised reset value); all other logic is flat.

Verification
REQ-030 Use BAUD_DIV=16 and frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop high) -> rx_data=0xA5, rx_valid rises after edge S+154, frame_err 0.
REQ-031 Apply a 4-cycle low glitch on an idle line -> no rx_valid, rx_busy returns low by S+11, no frame_err.
REQ-032 Send 0x3C with the stop bit low, then hold the line low 40 cycles -> one frame_err pulse, rx_data unchanged, state WAIT_HIGH until high.
REQ-033 Send 0x11 then 0x22 back-to-back with no rx_ack -> rx_data=0x11, overrun=1; then rx_ack -> rx_valid 0.
REQ-034 Assert rx_ack in the exact cycle 0x22 completes -> rx_data=0x22, rx_valid 1, overrun 0.
REQ-035 Assert rst during DATA bit 4 of 0x5A -> all outputs at reset values; the next frame 0x0F is received correctly.
